// File: rtl/ball_engine.sv
// ball_engine: serve/play/score ball mover with paddle deflection, wall clamping and rally speed-up
module ball_engine #(
  parameter int X_WIDTH          = 8,
  parameter int Y_WIDTH          = 9,
  parameter int X_START          = 115,
  parameter int Y_START          = 240,
  parameter int TOP_BOUND        = 175,
  parameter int BOTTOM_BOUND     = 310,
  parameter int LEFT_PADDLE_X    = 30,
  parameter int RIGHT_PADDLE_X   = 210,
  parameter int LEFT_GOAL        = 10,
  parameter int RIGHT_GOAL       = 230,
  parameter int BASE_SPEED       = 1,
  parameter int MAX_SPEED        = 4,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int SERVE_DELAY      = 60,
  parameter int SPEED_W          = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               serve,
  input  logic               leftHit,
  input  logic               rightHit,
  input  logic [1:0]         hitZone,
  output logic [X_WIDTH-1:0] ballXValue,
  output logic [Y_WIDTH-1:0] ballYValue,
  output logic               direction,
  output logic [SPEED_W-1:0] speed,
  output logic               inPlay,
  output logic               scoreLeft,
  output logic               scoreRight
);
  typedef enum logic [1:0] {IDLE, SERVE_WAIT, PLAY, SCORED} state_t;
  localparam int HW = $clog2(HITS_PER_SPEEDUP + 1);
  localparam int DW = SERVE_DELAY > 0 ? $clog2(SERVE_DELAY + 1) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(SERVE_DELAY > 0 ? SERVE_DELAY - 1 : 0);
  localparam logic [HW-1:0] HITS = HW'(HITS_PER_SPEEDUP);
  localparam logic [SPEED_W-1:0] BASE_SP = SPEED_W'(BASE_SPEED);
  localparam logic [SPEED_W-1:0] MAX_SP = SPEED_W'(MAX_SPEED);
  localparam logic [X_WIDTH:0] LPX = (X_WIDTH+1)'(LEFT_PADDLE_X);
  localparam logic [X_WIDTH:0] RPX = (X_WIDTH+1)'(RIGHT_PADDLE_X);
  localparam logic [X_WIDTH:0] LGX = (X_WIDTH+1)'(LEFT_GOAL);
  localparam logic [X_WIDTH:0] RGX = (X_WIDTH+1)'(RIGHT_GOAL);
  localparam logic [Y_WIDTH:0] TOPY = (Y_WIDTH+1)'(TOP_BOUND);
  localparam logic [Y_WIDTH:0] BOTY = (Y_WIDTH+1)'(BOTTOM_BOUND);
  localparam logic [X_WIDTH-1:0] XS = X_WIDTH'(X_START);
  localparam logic [Y_WIDTH-1:0] YS = Y_WIDTH'(Y_START);

  state_t state_q, state_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [DW-1:0] delay_cnt_q, delay_cnt_d;
  logic dir_q, dir_d, ydir_q, ydir_d, yflat_q, yflat_d, toggle_q, toggle_d;
  logic score_l_q, score_l_d, score_r_q, score_r_d;

  logic hit, flat_zone, wrap, dir_h, ydir_h, yflat_h, goal_l, goal_r, y_clamp;
  logic [HW-1:0] cnt_inc, hit_cnt_h;
  logic [SPEED_W-1:0] speed_h;
  logic [X_WIDTH:0] x_ext, sp_x, x_nxt;
  logic [Y_WIDTH:0] y_ext, step, y_dn, y_nxt;

  // Per-tick play arithmetic: hit effects first, then the moves using the post-hit speed and direction
  always_comb begin
    x_ext     = {1'b0, x_q};
    y_ext     = {1'b0, y_q};
    hit       = (!dir_q && leftHit && x_ext <= LPX) || (dir_q && rightHit && x_ext >= RPX);
    flat_zone = hitZone == 2'b00 || hitZone == 2'b11;
    dir_h     = dir_q ^ hit;
    ydir_h    = hit && !flat_zone ? hitZone[1] : ydir_q;
    yflat_h   = hit ? flat_zone : yflat_q;
    cnt_inc   = hit_cnt_q + 1'b1;
    wrap      = hit && cnt_inc == HITS;
    hit_cnt_h = hit ? (wrap ? '0 : cnt_inc) : hit_cnt_q;
    speed_h   = wrap && speed_q < MAX_SP ? speed_q + 1'b1 : speed_q;
    sp_x      = (X_WIDTH+1)'(speed_h);
    x_nxt     = dir_h ? x_ext + sp_x : x_ext - sp_x;
    goal_r    = !dir_h && (x_ext < sp_x || x_nxt <= LGX);
    goal_l    = dir_h && x_nxt >= RGX;
    step      = yflat_h ? '0 : (Y_WIDTH+1)'(speed_h);
    y_dn      = y_ext + step;
    y_clamp   = ydir_h ? y_dn > BOTY : y_ext < TOPY + step;
    y_nxt     = ydir_h ? (y_clamp ? BOTY : y_dn) : (y_clamp ? TOPY : y_ext - step);
  end

  // Next-state and register updates for the serve/play/score sequence
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    speed_d     = speed_q;
    hit_cnt_d   = hit_cnt_q;
    delay_cnt_d = delay_cnt_q;
    dir_d       = dir_q;
    ydir_d      = ydir_q;
    yflat_d     = yflat_q;
    toggle_d    = toggle_q;
    score_l_d   = 1'b0;
    score_r_d   = 1'b0;
    case (state_q)
      IDLE: if (serve) begin
        speed_d     = BASE_SP;
        hit_cnt_d   = '0;
        yflat_d     = 1'b0;
        ydir_d      = toggle_q;
        toggle_d    = !toggle_q;
        delay_cnt_d = '0;
        state_d     = SERVE_DELAY == 0 ? PLAY : SERVE_WAIT;
      end
      SERVE_WAIT: if (tick) begin
        delay_cnt_d = delay_cnt_q + 1'b1;
        state_d     = delay_cnt_q == D_LAST ? PLAY : SERVE_WAIT;
      end
      PLAY: if (tick) begin
        dir_d     = goal_r ? 1'b0 : goal_l ? 1'b1 : dir_h;
        ydir_d    = goal_r || goal_l ? ydir_h : ydir_h ^ y_clamp;
        yflat_d   = yflat_h;
        hit_cnt_d = hit_cnt_h;
        speed_d   = speed_h;
        score_r_d = goal_r;
        score_l_d = goal_l;
        state_d   = goal_r || goal_l ? SCORED : PLAY;
        x_d       = goal_r || goal_l ? x_q : x_nxt[X_WIDTH-1:0];
        y_d       = goal_r || goal_l ? y_q : y_nxt[Y_WIDTH-1:0];
      end
      default: begin
        x_d     = XS;
        y_d     = YS;
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset to the serve position
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= XS;
      y_q         <= YS;
      speed_q     <= BASE_SP;
      hit_cnt_q   <= '0;
      delay_cnt_q <= '0;
      dir_q       <= 1'b0;
      ydir_q      <= 1'b0;
      yflat_q     <= 1'b0;
      toggle_q    <= 1'b0;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      speed_q     <= speed_d;
      hit_cnt_q   <= hit_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      dir_q       <= dir_d;
      ydir_q      <= ydir_d;
      yflat_q     <= yflat_d;
      toggle_q    <= toggle_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
    end
  end

  assign ballXValue = x_q;
  assign ballYValue = y_q;
  assign direction  = dir_q;
  assign speed      = speed_q;
  assign inPlay     = state_q == PLAY;
  assign scoreLeft  = score_l_q;
  assign scoreRight = score_r_q;
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed rallies plus random play checked every cycle against a behavioural model
module tb_ball_engine;
  logic clock = 1'b0, reset = 1'b1, tick = 1'b0, serve = 1'b0, leftHit = 1'b0, rightHit = 1'b0;
  logic [1:0] hitZone = 2'b00;
  logic [7:0] ballXValue;
  logic [8:0] ballYValue;
  logic direction, inPlay, scoreLeft, scoreRight;
  logic [2:0] speed;
  int n_cmp = 0, n_bad = 0;

  ball_engine #(.SERVE_DELAY(3)) dut (
    .clock(clock), .reset(reset), .tick(tick), .serve(serve), .leftHit(leftHit),
    .rightHit(rightHit), .hitZone(hitZone), .ballXValue(ballXValue), .ballYValue(ballYValue),
    .direction(direction), .speed(speed), .inPlay(inPlay), .scoreLeft(scoreLeft),
    .scoreRight(scoreRight)
  );

  always #5 clock = ~clock;

  // Behavioural model: phase 0 idle, 1 waiting for serve delay, 2 rally, 3 goal just scored
  int phase, mx, my, mdir, msp, mydown, mflat, mhits, mwait, mtog, msl, msr, nx, st;
  always @(posedge clock) begin
    if (reset) begin
      phase = 0; mx = 115; my = 240; mdir = 0; msp = 1; mydown = 0; mflat = 0;
      mhits = 0; mwait = 0; mtog = 0; msl = 0; msr = 0;
    end else begin
      msl = 0; msr = 0;
      if (phase == 0) begin
        if (serve) begin
          msp = 1; mhits = 0; mflat = 0; mydown = mtog; mtog = 1 - mtog; mwait = 0; phase = 1;
        end
      end else if (phase == 1) begin
        if (tick) begin
          mwait++;
          if (mwait == 3) phase = 2;
        end
      end else if (phase == 2) begin
        if (tick) begin
          if (mdir == 0 ? (leftHit && mx <= 30) : (rightHit && mx >= 210)) begin
            mdir = 1 - mdir;
            if (hitZone == 1) begin mydown = 0; mflat = 0; end
            else if (hitZone == 2) begin mydown = 1; mflat = 0; end
            else mflat = 1;
            mhits++;
            if (mhits == 4) begin mhits = 0; if (msp < 4) msp++; end
          end
          nx = mdir ? mx + msp : mx - msp;
          st = mflat ? 0 : msp;
          if (nx <= 10) begin msr = 1; mdir = 0; phase = 3; end
          else if (nx >= 230) begin msl = 1; mdir = 1; phase = 3; end
          else begin
            mx = nx;
            if (mydown) begin
              if (my + st > 310) begin my = 310; mydown = 0; end else my += st;
            end else begin
              if (my < 175 + st) begin my = 175; mydown = 1; end else my -= st;
            end
          end
        end
      end else begin
        mx = 115; my = 240; phase = 0;
      end
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("x", ballXValue, mx);
    chk("y", ballYValue, my);
    chk("direction", direction, mdir);
    chk("speed", speed, msp);
    chk("inPlay", inPlay, phase == 2);
    chk("scoreLeft", scoreLeft, msl);
    chk("scoreRight", scoreRight, msr);
  endtask

  task automatic cyc(input logic t, input logic s, input logic lh, input logic rh, input logic [1:0] z);
    tick = t; serve = s; leftHit = lh; rightHit = rh; hitZone = z;
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_x", ballXValue, 115);
    chk("rst_y", ballYValue, 240);
    chk("rst_speed", speed, 1);
    chk("rst_inplay", inPlay, 0);
    reset = 1'b0;
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    chk("serve_inplay", inPlay, 1);
    cyc(1, 0, 0, 0, 0);
    chk("first_x", ballXValue, 114);
    chk("first_y", ballYValue, 239);
    for (int i = 0; i < 103; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_goal_x", ballXValue, 11);
    cyc(1, 0, 0, 0, 0);
    chk("goal_pulse", scoreRight, 1);
    chk("goal_dir", direction, 0);
    cyc(0, 0, 0, 0, 0);
    chk("post_goal_x", ballXValue, 115);
    chk("post_goal_y", ballYValue, 240);
    chk("post_goal_pulse", scoreRight, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 85; i++) cyc(1, 0, 0, 0, 0);
    chk("paddle_x", ballXValue, 30);
    cyc(1, 0, 1, 0, 2'b10);
    chk("deflect_dir", direction, 1);
    chk("deflect_x", ballXValue, 31);
    for (int i = 0; i < 20000; i++) begin
      reset = $urandom_range(0, 2999) == 0;
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
